// File: rtl/seg_rx_pkg.sv
// seg_rx_pkg
//   Shared definitions for the seven-segment frame receiver: frame geometry,
//   control (digit-select) codes, gfedcba segment patterns for 0..9, the
//   receive FSM state type and two small decode helpers.
package seg_rx_pkg;

   localparam int FRAME_BITS = 16;
   localparam int SEG_BITS   = 7;
   localparam int CTRL_BITS  = 9;
   // Bit counter saturates one past a full frame so "too long" stays sticky.
   localparam int CNT_MAX    = FRAME_BITS + 1;

   localparam logic [CTRL_BITS-1:0] CTRL_ONES      = 9'h040;
   localparam logic [CTRL_BITS-1:0] CTRL_TENS      = 9'h020;
   localparam logic [CTRL_BITS-1:0] CTRL_HUNDREDS  = 9'h008;
   localparam logic [CTRL_BITS-1:0] CTRL_THOUSANDS = 9'h004;

   // Active-high segment patterns, bit 0 = seg a ... bit 6 = seg g.
   localparam logic [SEG_BITS-1:0] SEG_0 = 7'h3F;
   localparam logic [SEG_BITS-1:0] SEG_1 = 7'h06;
   localparam logic [SEG_BITS-1:0] SEG_2 = 7'h5B;
   localparam logic [SEG_BITS-1:0] SEG_3 = 7'h4F;
   localparam logic [SEG_BITS-1:0] SEG_4 = 7'h66;
   localparam logic [SEG_BITS-1:0] SEG_5 = 7'h6D;
   localparam logic [SEG_BITS-1:0] SEG_6 = 7'h7D;
   localparam logic [SEG_BITS-1:0] SEG_7 = 7'h07;
   localparam logic [SEG_BITS-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_BITS-1:0] SEG_9 = 7'h6F;

   typedef enum logic [1:0] {
      S_IDLE,   // no bits since the last boundary
      S_SHIFT,  // 1..15 bits received
      S_FULL,   // exactly 16 bits received
      S_OVF     // more than 16 bits received
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] sel;
   } ctrl_dec_t;

   // Control field to digit position; only the four one-hot codes are legal.
   function automatic ctrl_dec_t decode_ctrl(input logic [CTRL_BITS-1:0] ctrl);
      ctrl_dec_t dec;
      dec.valid = 1'b1;
      dec.sel   = 2'd0;
      case (ctrl)
         CTRL_ONES:      dec.sel = 2'd0;
         CTRL_TENS:      dec.sel = 2'd1;
         CTRL_HUNDREDS:  dec.sel = 2'd2;
         CTRL_THOUSANDS: dec.sel = 2'd3;
         default:        dec.valid = 1'b0;
      endcase
      return dec;
   endfunction

   // Four BCD digits (index 0 = ones) to binary, truncated to the 13-bit
   // width of the driver input; values above 8191 wrap.
   function automatic logic [12:0] bcd_to_bin(input logic [3:0][3:0] digits);
      logic [13:0] full;
      full = 14'(digits[3]) * 14'd1000 + 14'(digits[2]) * 14'd100
           + 14'(digits[1]) * 14'd10   + 14'(digits[0]);
      return full[12:0];
   endfunction

endpackage

// File: rtl/seg_frame_receiver_if.sv
// seg_frame_receiver_if
//   Bundles the serial link and the decoded result bus of seg_frame_receiver.
//   master : the side that drives the serial link (sender / bench)
//   slave  : the receiver
//   Signals: i_segData, i_segLatch (link); o_frameValid, o_frameErr,
//   o_digitSel, o_digit, o_segPattern, o_value, o_valueValid (results).
interface seg_frame_receiver_if;

   logic        i_segData;
   logic        i_segLatch;
   logic        o_frameValid;
   logic        o_frameErr;
   logic [1:0]  o_digitSel;
   logic [3:0]  o_digit;
   logic [6:0]  o_segPattern;
   logic [12:0] o_value;
   logic        o_valueValid;

   modport master (
      output i_segData, i_segLatch,
      input  o_frameValid, o_frameErr, o_digitSel, o_digit, o_segPattern,
             o_value, o_valueValid
   );

   modport slave (
      input  i_segData, i_segLatch,
      output o_frameValid, o_frameErr, o_digitSel, o_digit, o_segPattern,
             o_value, o_valueValid
   );

endinterface

// File: rtl/seg_to_bcd.sv
// seg_to_bcd
//   Combinational decode of an active-high gfedcba pattern to a BCD digit.
//   i_pattern : 7-bit segment pattern (bit 0 = seg a)
//   o_valid   : pattern is one of the ten digit shapes
//   o_digit   : decoded digit, 0 when o_valid is low
module seg_to_bcd
   import seg_rx_pkg::*;
(
   input  logic [SEG_BITS-1:0] i_pattern,
   output logic                o_valid,
   output logic [3:0]          o_digit
);

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned; otherwise a latch is inferred.
   always_comb begin
      o_valid = 1'b1;
      o_digit = 4'd0;
      case (i_pattern)
         SEG_0:   o_digit = 4'd0;
         SEG_1:   o_digit = 4'd1;
         SEG_2:   o_digit = 4'd2;
         SEG_3:   o_digit = 4'd3;
         SEG_4:   o_digit = 4'd4;
         SEG_5:   o_digit = 4'd5;
         SEG_6:   o_digit = 4'd6;
         SEG_7:   o_digit = 4'd7;
         SEG_8:   o_digit = 4'd8;
         SEG_9:   o_digit = 4'd9;
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_frame_receiver.sv
// seg_frame_receiver
//   Far end of the seven-segment serial link. Shifts in 16-bit frames
//   (bit 0 first, i_segLatch high while shifting, low = boundary), checks
//   length, control code and segment shape, and reports the decoded digit.
//   Optional macro SEG_RX_BIN_EN builds the BCD-to-binary stage that
//   rebuilds the 13-bit displayed value once all four digits were seen.
//   Parameter SEG_ACTIVE_LOW : invert segment bits before decode.
//   Ports: i_clk, i_rst (synchronous, active-high), bus (slave modport).
module seg_frame_receiver
   import seg_rx_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   seg_frame_receiver_if.slave  bus
);

   state_t                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic [1:0]            digit_sel_q, digit_sel_d;
   logic [3:0]            digit_q, digit_d;
   logic [SEG_BITS-1:0]   seg_pattern_q, seg_pattern_d;

   logic [SEG_BITS-1:0]   seg_fixed;
   logic                  pat_ok;
   logic [3:0]            pat_digit;
   ctrl_dec_t             ctrl_dec;
   logic                  frame_end;
   logic                  frame_good;

   // Decode always looks at the assembled word; it is only acted on at a
   // boundary, when the word is complete.
   assign seg_fixed = SEG_ACTIVE_LOW ? ~shift_q[FRAME_BITS-1 -: SEG_BITS]
                                     :  shift_q[FRAME_BITS-1 -: SEG_BITS];
   assign ctrl_dec  = decode_ctrl(shift_q[CTRL_BITS-1:0]);

   seg_to_bcd u_seg_to_bcd (
      .i_pattern (seg_fixed),
      .o_valid   (pat_ok),
      .o_digit   (pat_digit)
   );

   // A boundary in S_IDLE is just an idle gap, not a frame.
   assign frame_end  = !bus.i_segLatch && (state_q != S_IDLE);
   assign frame_good = frame_end && (state_q == S_FULL) && ctrl_dec.valid && pat_ok;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      digit_sel_d   = digit_sel_q;
      digit_d       = digit_q;
      seg_pattern_d = seg_pattern_q;

      if (!bus.i_segLatch) begin
         state_d = S_IDLE;
         cnt_d   = 5'd0;
         if (frame_end) begin
            seg_pattern_d = seg_fixed;
            if (frame_good) begin
               frame_valid_d = 1'b1;
               digit_sel_d   = ctrl_dec.sel;
               digit_d       = pat_digit;
            end else begin
               frame_err_d = 1'b1;
            end
         end
      end else begin
         // Newest bit enters at the top, so the first bit ends in word[0].
         shift_d = {bus.i_segData, shift_q[FRAME_BITS-1:1]};
         cnt_d   = (cnt_q == 5'(CNT_MAX)) ? cnt_q : cnt_q + 5'd1;
         case (state_q)
            S_IDLE:  state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 5'(FRAME_BITS - 1)) state_d = S_FULL;
            S_FULL:  state_d = S_OVF;
            default: state_d = S_OVF;
         endcase
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 5'd0;
         shift_q       <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         digit_sel_q   <= 2'd0;
         digit_q       <= 4'd0;
         seg_pattern_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         digit_sel_q   <= digit_sel_d;
         digit_q       <= digit_d;
         seg_pattern_q <= seg_pattern_d;
      end
   end

   assign bus.o_frameValid = frame_valid_q;
   assign bus.o_frameErr   = frame_err_q;
   assign bus.o_digitSel   = digit_sel_q;
   assign bus.o_digit      = digit_q;
   assign bus.o_segPattern = seg_pattern_q;

`ifdef SEG_RX_BIN_EN
   // Digit registers only feed the binary stage, so they live with it.
   logic [3:0][3:0] digits_q, digits_d;
   logic [3:0]      seen_q, seen_d, seen_next;
   logic            calc_q, calc_d;
   logic [12:0]     value_q, value_d;
   logic            value_valid_q, value_valid_d;

   always_comb begin
      digits_d      = digits_q;
      seen_d        = seen_q;
      calc_d        = 1'b0;
      value_d       = value_q;
      value_valid_d = 1'b0;
      seen_next     = seen_q | (4'b0001 << ctrl_dec.sel);

      if (frame_good) begin
         digits_d[ctrl_dec.sel] = pat_digit;
         // Thousands closes a display scan; convert one cycle later, once
         // the thousands digit itself is in its register.
         if ((ctrl_dec.sel == 2'd3) && (seen_next == 4'hF)) begin
            seen_d = 4'h0;
            calc_d = 1'b1;
         end else begin
            seen_d = seen_next;
         end
      end

      if (calc_q) begin
         value_d       = bcd_to_bin(digits_q);
         value_valid_d = 1'b1;
      end
   end

   // NOTE: the digit registers are a handful of flops, not a RAM, so they
   // take the reset like everything else and never read back as X.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         digits_q      <= '0;
         seen_q        <= 4'h0;
         calc_q        <= 1'b0;
         value_q       <= 13'd0;
         value_valid_q <= 1'b0;
      end else begin
         digits_q      <= digits_d;
         seen_q        <= seen_d;
         calc_q        <= calc_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
      end
   end

   assign bus.o_value      = value_q;
   assign bus.o_valueValid = value_valid_q;
`else
   assign bus.o_value      = 13'd0;
   assign bus.o_valueValid = 1'b0;
`endif

endmodule

// File: tb/tb_seg_frame_receiver.sv
// tb_seg_frame_receiver
//   Bench for seg_frame_receiver: directed frames from the display-path
//   scenarios followed by random frames, compared every cycle against a
//   frame-level model. A second instance covers the inverted-segment build.
module tb_seg_frame_receiver;

   localparam bit [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   localparam bit [8:0] CTRL_TBL [4] = '{9'h040, 9'h020, 9'h008, 9'h004};
`ifdef SEG_RX_BIN_EN
   localparam logic [12:0] EXP_1234 = 13'd1234;
`else
   localparam logic [12:0] EXP_1234 = 13'd0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_frame_receiver_if bus  ();
   seg_frame_receiver_if bus2 ();

   seg_frame_receiver #(.SEG_ACTIVE_LOW(1'b0)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   seg_frame_receiver #(.SEG_ACTIVE_LOW(1'b1)) u_dut_al (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2)
   );

   int checks = 0;
   int errors = 0;

   // Model state: bits of the frame in progress, the last 16 bits shifted
   // since reset, and the outputs expected at the current sample point.
   bit          frame_bits[$];
   bit          hist[$];
   bit          exp_fv, exp_fe, exp_vv;
   bit [1:0]    m_sel;
   bit [3:0]    m_dig;
   bit [6:0]    m_pat;
   bit [12:0]   m_val;
   bit          vv_pend;
   bit [12:0]   val_pend;
   bit          prev_d, prev_l;
`ifdef SEG_RX_BIN_EN
   int          m_digits[4];
   bit [3:0]    m_seen;
`endif

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int pattern_digit(input bit [6:0] p);
      for (int i = 0; i < 10; i++) if (SEG_LUT[i] == p) return i;
      return -1;
   endfunction

   function automatic int ctrl_sel(input bit [8:0] c);
      for (int i = 0; i < 4; i++) if (CTRL_TBL[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      frame_bits.delete();
      hist.delete();
      exp_fv = 0; exp_fe = 0; exp_vv = 0;
      m_sel = 0; m_dig = 0; m_pat = 0; m_val = 0;
      vv_pend = 0; val_pend = 0;
      prev_d = 0; prev_l = 0;
`ifdef SEG_RX_BIN_EN
      for (int i = 0; i < 4; i++) m_digits[i] = 0;
      m_seen = 0;
`endif
   endtask

   // Apply one sampled (data, latch) pair to the model.
   task automatic model_sample(input bit d, input bit l);
      bit [15:0] word;
      int        n, dg, s;
      exp_fv = 0;
      exp_fe = 0;
      if (l) begin
         frame_bits.push_back(d);
         hist.push_back(d);
         if (hist.size() > 16) void'(hist.pop_front());
      end else if (frame_bits.size() > 0) begin
         // Most recent bit is word[15]; bits never received read as 0.
         word = '0;
         n = hist.size();
         for (int k = 0; k < n; k++) word[15-k] = hist[n-1-k];
         m_pat = word[15:9];
         dg = pattern_digit(word[15:9]);
         s  = ctrl_sel(word[8:0]);
         if (frame_bits.size() == 16 && dg >= 0 && s >= 0) begin
            exp_fv = 1;
            m_sel  = 2'(s);
            m_dig  = 4'(dg);
`ifdef SEG_RX_BIN_EN
            m_digits[s] = dg;
            m_seen[s]   = 1'b1;
            if (s == 3 && m_seen == 4'hF) begin
               vv_pend  = 1;
               val_pend = 13'((1000*m_digits[3] + 100*m_digits[2]
                              + 10*m_digits[1] + m_digits[0]) % 8192);
               m_seen   = 0;
            end
`endif
         end else begin
            exp_fe = 1;
         end
         frame_bits.delete();
      end
   endtask

   // One link cycle: compare outputs produced by the previous sample, then
   // drive the next (data, latch) pair on the falling edge.
   task automatic step(input bit d, input bit l);
      @(negedge clk);
      exp_vv = vv_pend;
      if (vv_pend) m_val = val_pend;
      vv_pend = 0;
      model_sample(prev_d, prev_l);
      check("frame_valid", 16'(bus.o_frameValid), 16'(exp_fv));
      check("frame_err",   16'(bus.o_frameErr),   16'(exp_fe));
      check("digit_sel",   16'(bus.o_digitSel),   16'(m_sel));
      check("digit",       16'(bus.o_digit),      16'(m_dig));
      check("seg_pattern", 16'(bus.o_segPattern), 16'(m_pat));
      check("value",       16'(bus.o_value),      16'(m_val));
      check("value_valid", 16'(bus.o_valueValid), 16'(exp_vv));
      bus.i_segData  = d;
      bus.i_segLatch = l;
      prev_d = d;
      prev_l = l;
   endtask

   task automatic send_word(input bit [15:0] word, input int nbits);
      for (int i = 0; i < nbits; i++) step((i < 16) ? word[i] : 1'($urandom), 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_segData  = 1'b0;
      bus.i_segLatch = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      bit [15:0] w;
      bit [15:0] w2;
      int        kind, len;

      bus.i_segData   = 1'b0;
      bus.i_segLatch  = 1'b0;
      bus2.i_segData  = 1'b0;
      bus2.i_segLatch = 1'b0;
      model_reset();
      do_reset();
      step(1'b0, 1'b0);

      // Display scan 1234, frames back-to-back.
      send_word(16'hCC40, 16);
      send_word(16'h9E20, 16);
      send_word(16'hB608, 16);
      send_word(16'h0C04, 16);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("value_1234", 16'(bus.o_value), 16'(EXP_1234));

      // Short and long frames.
      send_word(16'hCC40, 15);
      send_word(16'hCC40, 17);

      // Bad control must not disturb the ones digit (4) stored next.
      send_word(16'hCC40, 16);
      send_word({7'h06, 9'h041}, 16);
      send_word(16'h9E20, 16);
      send_word(16'hB608, 16);
      send_word(16'h0C04, 16);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("value_kept", 16'(bus.o_value), 16'(EXP_1234));

      // Blank segments with a legal control code.
      send_word(16'h0040, 16);
      step(1'b0, 1'b0);
      check("blank_pattern", 16'(bus.o_segPattern), 16'h0000);

      // Reset part-way through a frame, then a lone thousands frame.
      for (int i = 0; i < 8; i++) step(w[i] ^ 1'b1, 1'b1);
      do_reset();
      step(1'b0, 1'b0);
      send_word(16'h0C04, 16);
      step(1'b0, 1'b0);
      check("post_rst_sel",   16'(bus.o_digitSel), 16'd3);
      check("post_rst_digit", 16'(bus.o_digit),    16'd1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Random traffic: mostly good frames, some bad length/control/shape.
      for (int f = 0; f < 160; f++) begin
         kind = $urandom_range(0, 9);
         len  = 16;
         if (kind == 0) begin
            w   = 16'($urandom);
            len = $urandom_range(1, 20);
            if (len == 16) len = 15;
         end else if (kind == 1) begin
            w = {SEG_LUT[$urandom_range(0, 9)], 9'($urandom)};
         end else if (kind == 2) begin
            w = {7'($urandom), CTRL_TBL[$urandom_range(0, 3)]};
         end else begin
            w = {SEG_LUT[$urandom_range(0, 9)], CTRL_TBL[$urandom_range(0, 3)]};
         end
         send_word(w, len);
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Inverted-segment instance: ones frame showing a 4.
      w2 = {~7'h66, 9'h040};
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus2.i_segData  = w2[i];
         bus2.i_segLatch = 1'b1;
      end
      @(negedge clk);
      bus2.i_segLatch = 1'b0;
      @(negedge clk);
      check("al_valid",   16'(bus2.o_frameValid), 16'd1);
      check("al_err",     16'(bus2.o_frameErr),   16'd0);
      check("al_sel",     16'(bus2.o_digitSel),   16'd0);
      check("al_digit",   16'(bus2.o_digit),      16'd4);
      check("al_pattern", 16'(bus2.o_segPattern), 16'h0066);
      @(negedge clk);
      check("al_pulse_end", 16'(bus2.o_frameValid), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_frame_receiver.md
# seg_frame_receiver

Serial-to-parallel receiver for the seven-segment display link: the far end of the segment driver's 16-bit serial data/latch stream. It reassembles each frame and decodes the 7-bit segment pattern back to a BCD digit. It uses the 9-bit digit-select field to place the digit, and optionally rebuilds the 13-bit binary value on display. It serves as an on-board loopback monitor and as a self-checking bench element for the display path.

## Interface
- SEG_ACTIVE_LOW, 0: when 1, segment bits are inverted before decode.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_segData  in  1  serial data; frame bit 0 first.
- i_segLatch  in  1  high = shifting; low for one or more cycles = frame boundary.
- o_frameValid  out  1  one-cycle pulse: good frame decoded.
- o_frameErr  out  1  one-cycle pulse: bad frame (length, select, or pattern).
- o_digitSel  out  2  0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
- o_digit  out  4  decoded BCD digit of last good frame.
- o_segPattern  out  7  raw segment field of last frame (after polarity fix).
- o_value  out  13  thousands*1000 + hundreds*100 + tens*10 + ones.
- o_valueValid  out  1  one-cycle pulse when o_value updates.

## Operation
- Frame: 16 bits, word[15:9] = segments (word[9] = seg a … word[15] = seg g), word[8:0] = control.
- Sampling: i_segData and i_segLatch are sampled on each rising i_clk. The sender changes them on the falling edge.
- Shift: while latch is high, shift right: new bit enters word[15], so the first bit lands in word[0] after 16 samples.
- Bit counter 0..17, saturates at 17.
- FSM:
  - S_IDLE (cnt 0): latch high → S_SHIFT.
  - S_SHIFT: latch high → keep shifting; on the 16th bit → S_FULL.
  - S_FULL: another bit → S_OVF; latch low → frame check.
  - S_OVF: latch low → error.
  - Every latch-low sample returns the FSM to S_IDLE with cnt 0.
- Latch low in S_IDLE: idle, no pulse. Consecutive low cycles are harmless.
- Latch low with cnt 1..15 or 17: o_frameErr.
- Control decode:
  - 9'h040 → sel 0
  - 9'h020 → sel 1
  - 9'h008 → sel 2
  - 9'h004 → sel 3
  - any other value → o_frameErr.
- Segment decode (gfedcba, active-high): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9. Anything else → o_frameErr.
- On a good frame: update o_digitSel, o_digit, o_segPattern, write the digit register for that select, and set that digit's seen bit.
- On an error: o_segPattern still updates; digit registers and seen bits are unchanged.
- After a good thousands frame with all four seen bits set: compute o_value, pulse o_valueValid, clear the seen bits.
- o_value width: max 9999 fits in 14 bits. The result is truncated to 13 bits (values above 8191 wrap), matching the driver input width.

## Timing
- Reset values:
  - all outputs 0
  - FSM S_IDLE, cnt 0, shift register 0
  - digit registers 0, seen bits 0
- i_rst mid-frame: the partial frame is discarded and no pulse is produced.
- o_frameValid / o_frameErr: registered, asserted the cycle after the latch-low sample.
- o_valueValid / o_value: one cycle after the corresponding o_frameValid (2 cycles after latch-low).
- Minimum frame period: 17 cycles (16 shift + 1 latch-low). Back-to-back frames are supported with no gap.
- Latch high in the cycle right after latch-low starts a new frame immediately.

## Configuration
- SEG_RX_BIN_EN defined: the BCD-to-binary stage and seen tracking are built; o_value and o_valueValid behave as above.
- Not defined: o_value is tied to 0, o_valueValid is tied to 0, and the seen bits are removed. All other behaviour is identical.

## Structure
- Package seg_rx_pkg holds:
  - FRAME_BITS = 16
  - the four control-code constants
  - the ten segment-pattern constants
  - the FSM state typedef
- Sub-module seg_to_bcd: combinational 7-bit pattern → {valid, 4-bit digit}, using the package constants.

## Test plan
- Frames 0xCC40, 0x9E20, 0xB608, 0x0C04 sent back-to-back → four o_frameValid pulses:
  - sel/digit 0/4, 1/3, 2/2, 3/1
  - then o_value = 1234 with o_valueValid.
- 15 bits then latch low → o_frameErr. Then 17 bits then latch low → o_frameErr. No o_frameValid in either case.
- Frame 0xCC41 (control 9'h041) → o_frameErr; digit registers are unchanged.
- Frame with segments 7'h00, control 9'h040 → o_frameErr; o_segPattern = 0.
- i_rst asserted after 8 bits, then a full 0x0C04 frame → no pulse for the aborted frame, then o_frameValid with sel 3, digit 1. No o_valueValid, because the seen bits were cleared by reset.
- SEG_ACTIVE_LOW = 1 with frame ~{7'h66} & control 9'h040 → sel 0, digit 4.
